// File: rtl/tone_pkg.sv
// Shared types and constants for the multi-channel tone generator.
// Frequencies are centi-Hz; half-periods are clock cycles.
package tone_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    COMMIT
  } state_t;

  localparam longint unsigned CLK_HZ_DEF = 64'd125000000;
  localparam int unsigned FREQ_MAX = 999999;
  localparam longint unsigned NUMER = CLK_HZ_DEF * 64'd50;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle.
// Runs exactly W cycles after start; done flags the last one.
module seq_divider #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] numerator,
  input  logic [W-1:0] denominator,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient
);

  localparam int IW = $clog2(W + 1);

  logic [W-1:0]  rem;
  logic [W-1:0]  d;
  logic [W-1:0]  nq;
  logic [IW-1:0] step;
  logic [W:0]    rem_sh;
  logic          ge;

  // nq shifts numerator bits out and quotient bits in
  assign rem_sh   = {rem, nq[W-1]};
  assign ge       = rem_sh >= {1'b0, d};
  assign done     = busy && (step == IW'(W - 1));
  assign quotient = nq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem  <= '0;
      d    <= '0;
      nq   <= '0;
      step <= '0;
      busy <= 1'b0;
    end else if (start) begin
      rem  <= '0;
      d    <= denominator;
      nq   <= numerator;
      step <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      rem  <= ge ? W'(rem_sh - {1'b0, d})
                 : rem_sh[W-1:0];
      nq   <= {nq[W-2:0], ge};
      step <= step + IW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/multi_tone_generator.sv
// Multi-channel square-wave generator; one shared divider turns
// centi-Hz codes into half-periods that load at output edges.
module multi_tone_generator #(
  parameter longint unsigned CLK_HZ = tone_pkg::CLK_HZ_DEF,
  parameter int NUM_CH = 4,
  parameter int FREQ_W = 32,
  parameter int CNT_W = 34,
  parameter int unsigned FREQ_MAX = tone_pkg::FREQ_MAX
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 cfg_valid,
  output logic                                 cfg_ready,
  input  logic [tone_pkg::ch_w(NUM_CH)-1:0]    cfg_ch,
  input  logic [FREQ_W-1:0]                    cfg_freq,
  input  logic                                 phase_sync,
  output logic [NUM_CH-1:0]                    wave_out
);

  import tone_pkg::*;

  localparam int CHW = ch_w(NUM_CH);
  localparam longint unsigned NUM =
    (CLK_HZ == CLK_HZ_DEF) ? NUMER : CLK_HZ * 64'd50;

  state_t           state, state_n;
  logic             hs, commit, f_zero;
  logic             div_start, div_busy, div_done;
  logic [CHW-1:0]   ch_q;
  logic [FREQ_W-1:0] f_sat;
  logic [CNT_W-1:0] f_ext, numer, quot, h_new;

  assign f_sat = (cfg_freq > FREQ_W'(FREQ_MAX))
               ? FREQ_W'(FREQ_MAX) : cfg_freq;
  assign f_ext = CNT_W'(f_sat);
  // adding f/2 rounds the quotient to nearest
  assign numer = CNT_W'(NUM) + (f_ext >> 1);
  assign hs = cfg_valid & cfg_ready;
  assign div_start = hs && (f_sat != '0);
  assign h_new = f_zero ? '0 : quot;

  seq_divider #(.W(CNT_W)) u_div (
    .clk         (clk),
    .rst         (rst),
    .start       (div_start),
    .numerator   (numer),
    .denominator (f_ext),
    .busy        (div_busy),
    .done        (div_done),
    .quotient    (quot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ch_q   <= '0;
      f_zero <= 1'b1;
    end else begin
      state <= state_n;
      if (hs) begin
        ch_q   <= cfg_ch;
        f_zero <= (f_sat == '0);
      end
    end
  end

  always_comb begin
    state_n   = state;
    cfg_ready = 1'b0;
    commit    = 1'b0;
    unique case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid)
          state_n = (f_sat == '0) ? COMMIT : DIV;
      end
      DIV: begin
        if (div_done || !div_busy) state_n = COMMIT;
      end
      COMMIT: begin
        commit  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt, h_act, pend_h;
    logic pend_v, out, run, wrap, load, we;

    assign run  = h_act != '0;
    assign wrap = cnt == (h_act - CNT_W'(1));
    assign we   = commit && (ch_q == CHW'(i));
    // running channels only take new periods at a toggle
    assign load = pend_v && !(run && phase_sync)
                && (!run || wrap);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt   <= '0;
        h_act <= '0;
        out   <= 1'b0;
      end else if (run && phase_sync) begin
        cnt <= '0;
        out <= 1'b0;
      end else if (!run) begin
        cnt <= '0;
        if (load) h_act <= pend_h;
      end else if (wrap) begin
        cnt <= '0;
        if (load) h_act <= pend_h;
        out <= (load && pend_h == '0) ? 1'b0 : ~out;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pend_h <= '0;
        pend_v <= 1'b0;
      end else if (we) begin
        pend_h <= h_new;
        pend_v <= 1'b1;
      end else if (load) begin
        pend_v <= 1'b0;
      end
    end

    assign wave_out[i] = out;
  end

endmodule

// File: tb/tb_multi_tone_generator.sv
// Bench for multi_tone_generator: countdown tone model checked
// every cycle, plus literal timing checks on directed scenarios.
module tb_multi_tone_generator;

  localparam int NCH = 4;
  localparam int CW  = 34;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_ch = '0;
  logic [31:0] cfg_freq = '0;
  logic        phase_sync = 1'b0;
  logic [3:0]  wave_out;

  int     tests = 0;
  int     fails = 0;
  longint cyc = 0;
  bit     chk_en = 1'b0;

  multi_tone_generator dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_freq   (cfg_freq),
    .phase_sync (phase_sync),
    .wave_out   (wave_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: per channel, active half-period, cycles left in the
  // current half, output level, and one pending slot.
  longint m_h[NCH];
  longint m_rem[NCH];
  longint m_ph[NCH];
  bit     m_out[NCH];
  bit     m_pv[NCH];
  int     m_wait;
  int     m_ch;
  longint m_newh;

  function automatic longint h_of(input longint f);
    longint fs;
    fs = (f > 999999) ? 999999 : f;
    if (fs == 0) return 0;
    return (64'd6250000000 + fs / 2) / fs;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_h[c] = 0; m_rem[c] = 0; m_ph[c] = 0;
      m_out[c] = 0; m_pv[c] = 0;
    end
    m_wait = 0;
  endtask

  task automatic model_step();
    bit used;
    for (int c = 0; c < NCH; c++) begin
      used = 0;
      if (m_h[c] != 0 && phase_sync) begin
        m_rem[c] = m_h[c];
        m_out[c] = 0;
      end else if (m_h[c] == 0) begin
        if (m_pv[c]) begin
          m_h[c] = m_ph[c];
          m_rem[c] = m_ph[c];
          used = 1;
        end
      end else if (m_rem[c] == 1) begin
        m_out[c] = !m_out[c];
        if (m_pv[c]) begin
          m_h[c] = m_ph[c];
          used = 1;
          if (m_h[c] == 0) m_out[c] = 0;
        end
        m_rem[c] = m_h[c];
      end else begin
        m_rem[c]--;
      end
      if (used) m_pv[c] = 0;
    end
    if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        m_ph[m_ch] = m_newh;
        m_pv[m_ch] = 1;
      end
    end else if (cfg_valid) begin
      m_ch = int'(cfg_ch);
      m_newh = h_of(longint'(cfg_freq));
      m_wait = (m_newh == 0) ? 1 : CW + 1;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  initial begin
    logic [3:0] exp_w;
    forever begin
      @(negedge clk);
      if (chk_en && !rst) begin
        exp_w = {m_out[3], m_out[2], m_out[1], m_out[0]};
        tests++;
        if (wave_out !== exp_w || cfg_ready !== (m_wait == 0)) begin
          fails++;
          $display("FAIL cycle_check cyc=%0d wave_out=%b cfg_ready=%b expected wave_out=%b cfg_ready=%b",
                   cyc, wave_out, cfg_ready, exp_w, (m_wait == 0));
        end
      end
    end
  end

  task automatic check(input string name, input longint act,
                       input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Handshake one request; optionally spray ignored requests while busy.
  task automatic cfg(input int ch, input longint f, input bit spam,
                     output int low);
    int n;
    n = 0;
    while (cfg_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    cfg_valid = 1'b1;
    cfg_ch    = ch[1:0];
    cfg_freq  = f[31:0];
    @(negedge clk);
    cfg_valid = 1'b0;
    low = 0;
    while (cfg_ready !== 1'b1 && low < 200) begin
      if (spam) begin
        cfg_valid = 1'($urandom_range(0, 1));
        cfg_ch    = 2'($urandom_range(0, 3));
        cfg_freq  = $urandom_range(1000, 3000000);
      end
      @(negedge clk);
      low++;
    end
    cfg_valid = 1'b0;
  endtask

  task automatic wait_level(input int ch, input bit lvl,
                            input int budget, output int n);
    n = 0;
    while (wave_out[ch] !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic count_rises(input int ch, input int len,
                             output int r);
    bit prev;
    r = 0;
    prev = wave_out[ch];
    repeat (len) begin
      @(negedge clk);
      if (wave_out[ch] && !prev) r++;
      prev = wave_out[ch];
    end
  endtask

  task automatic count_toggles(input int ch, input int len,
                               output int r);
    bit prev;
    r = 0;
    prev = wave_out[ch];
    repeat (len) begin
      @(negedge clk);
      if (wave_out[ch] != prev) r++;
      prev = wave_out[ch];
    end
  endtask

  initial begin
    #990000;
    fails++;
    $display("FAIL watchdog cyc=%0d limit reached", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int n, r;
    longint t0, f;
    int ch;

    check("h_987654", h_of(987654), 6328);
    check("h_44000", h_of(44000), 142045);
    check("h_100000", h_of(100000), 62500);
    check("h_sat", h_of(2000000), 6250);

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_wave", longint'(wave_out), 0);
    check("reset_ready", longint'(cfg_ready), 1);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    cfg(0, 987654, 1'b0, n);
    check("ch0_busy", n, 35);
    wait_level(0, 1'b1, 7000, n);
    check("ch0_first_rise", n, 6329);
    wait_level(0, 1'b0, 7000, n);
    check("ch0_high", n, 6328);
    wait_level(0, 1'b1, 7000, n);
    check("ch0_low", n, 6328);

    cfg(1, 44000, 1'b0, n);
    check("ch1_busy", n, 35);
    cfg(2, 100000, 1'b1, n);
    check("ch2_busy", n, 35);

    cfg(3, 2000000, 1'b0, n);
    cfg(0, 2000000, 1'b0, n);
    repeat (6500) @(negedge clk);
    phase_sync = 1'b1;
    @(negedge clk);
    phase_sync = 1'b0;
    check("sync_all_low", longint'(wave_out), 0);
    wait_level(0, 1'b1, 7000, n);
    check("sync_rise_ch0", n, 6250);
    check("sync_rise_ch3", longint'(wave_out[3]), 1);

    cfg(3, 0, 1'b0, n);
    check("ch3_off_busy", n, 1);
    repeat (6300) @(negedge clk);
    check("ch3_off", longint'(wave_out[3]), 0);
    count_rises(3, 5000, r);
    check("ch3_no_rise", r, 0);

    wait_level(0, 1'b0, 7000, n);
    wait_level(0, 1'b1, 7000, n);
    t0 = cyc;
    repeat ($urandom_range(300, 3000)) @(negedge clk);
    cfg(0, 100000, 1'b0, n);
    wait_level(0, 1'b0, 7000, n);
    check("ch0_old_half", cyc - t0, 6250);
    count_toggles(0, 6000, r);
    check("ch0_new_half_hold", r, 0);

    cfg_valid = 1'b1;
    cfg_ch    = 2'd2;
    cfg_freq  = 32'd123456;
    @(negedge clk);
    cfg_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_wave", longint'(wave_out), 0);
    check("rst_ready", longint'(cfg_ready), 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      ch = int'($urandom_range(0, 3));
      f = ($urandom_range(0, 4) == 0) ? 0
        : longint'($urandom_range(600000, 3000000));
      cfg(ch, f, 1'b1, n);
      check("rand_busy", n, (f == 0) ? 1 : 35);
      repeat ($urandom_range(200, 1000)) @(negedge clk);
      if ($urandom_range(0, 2) == 0) begin
        phase_sync = 1'b1;
        @(negedge clk);
        phase_sync = 1'b0;
      end
    end
    repeat (2000) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
